// File: rtl/memory_stage_if.sv
// Upstream request and write-back response bundle for memory_stage.
interface memory_stage_if;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned REG_W = 5;

  logic             in_valid;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  store_data;
  logic [REG_W-1:0] rd_in;

  logic             stall;
  logic             wb_valid;
  logic [XLEN-1:0]  wb_data;
  logic [REG_W-1:0] wb_rd;
  logic             wb_reg_write;
  logic             misalign;

  modport master (
    output in_valid, mem_read, mem_write, mem_to_reg, reg_write,
           alu_result, store_data, rd_in,
    input  stall, wb_valid, wb_data, wb_rd, wb_reg_write, misalign
  );

  modport slave (
    input  in_valid, mem_read, mem_write, mem_to_reg, reg_write,
           alu_result, store_data, rd_in,
    output stall, wb_valid, wb_data, wb_rd, wb_reg_write, misalign
  );
endinterface

// File: rtl/memory_stage.sv
// RISC-V memory stage: doubleword data memory with fixed access latency.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module memory_stage #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  memory_stage_if.slave bus
);
  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               op_write_q, op_write_d;
  logic               op_to_reg_q, op_to_reg_d;
  logic               op_reg_write_q, op_reg_write_d;
  logic [REG_W-1:0]   op_rd_q, op_rd_d;
  logic [XLEN-1:0]    op_addr_q, op_addr_d;
  logic [XLEN-1:0]    op_data_q, op_data_d;

  logic               stall_q, stall_d;
  logic               wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;
  logic [REG_W-1:0]   wb_rd_q, wb_rd_d;
  logic               wb_reg_write_q, wb_reg_write_d;

  logic               sel_lat_c;
  logic               cur_is_mem_c;
  logic               cur_write_c;
  logic               cur_to_reg_c;
  logic               cur_reg_write_c;
  logic [REG_W-1:0]   cur_rd_c;
  logic [XLEN-1:0]    cur_addr_c;
  logic [XLEN-1:0]    cur_data_c;
  logic [ADDR_W-1:0]  mem_idx_c;
  logic               complete_c;
  logic               mis_c;
  logic               mem_we_c;

  logic [XLEN-1:0]    mem [DEPTH];

  // Operation being completed: the latched one in WAIT, the live input otherwise.
  always_comb begin : op_view
    sel_lat_c       = (state_q == WAIT);
    cur_is_mem_c    = sel_lat_c ? 1'b1           : (bus.mem_read | bus.mem_write);
    cur_write_c     = sel_lat_c ? op_write_q     : bus.mem_write;
    cur_to_reg_c    = sel_lat_c ? op_to_reg_q    : bus.mem_to_reg;
    cur_reg_write_c = sel_lat_c ? op_reg_write_q : bus.reg_write;
    cur_rd_c        = sel_lat_c ? op_rd_q        : bus.rd_in;
    cur_addr_c      = sel_lat_c ? op_addr_q      : bus.alu_result;
    cur_data_c      = sel_lat_c ? op_data_q      : bus.store_data;
    mem_idx_c       = cur_addr_c[ADDR_W+2:3];
  end

  always_comb begin : fsm_next
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_write_d     = op_write_q;
    op_to_reg_d    = op_to_reg_q;
    op_reg_write_d = op_reg_write_q;
    op_rd_d        = op_rd_q;
    op_addr_d      = op_addr_q;
    op_data_d      = op_data_q;
    stall_d        = 1'b0;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    complete_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (cur_is_mem_c && !mis_c && (LAT != '0)) begin
            state_d        = WAIT;
            cnt_d          = LAT;
            stall_d        = 1'b1;
            op_write_d     = bus.mem_write;
            op_to_reg_d    = bus.mem_to_reg;
            op_reg_write_d = bus.reg_write;
            op_rd_d        = bus.rd_in;
            op_addr_d      = bus.alu_result;
            op_data_d      = bus.store_data;
          end else begin
            complete_c = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = IDLE;
          complete_c = 1'b1;
        end else begin
          stall_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A simultaneous read+write is a store, so only pure loads return memory data.
    if (complete_c) begin
      wb_valid_d     = 1'b1;
      wb_rd_d        = cur_rd_c;
      wb_reg_write_d = cur_reg_write_c && (cur_rd_c != '0) && !mis_c;
      wb_data_d      = cur_addr_c;
      if (cur_is_mem_c && !cur_write_c && cur_to_reg_c && !mis_c) begin
        wb_data_d = mem[mem_idx_c];
      end
    end
  end

  // Reset suppresses the write so an interrupted store never lands.
  assign mem_we_c = rst_n && complete_c && cur_is_mem_c && cur_write_c && !mis_c;

  always_ff @(posedge clk) begin : mem_write_port
    if (mem_we_c) begin
      mem[mem_idx_c] <= cur_data_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_regs
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      op_write_q     <= 1'b0;
      op_to_reg_q    <= 1'b0;
      op_reg_write_q <= 1'b0;
      op_rd_q        <= '0;
      op_addr_q      <= '0;
      op_data_q      <= '0;
      stall_q        <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_write_q     <= op_write_d;
      op_to_reg_q    <= op_to_reg_d;
      op_reg_write_q <= op_reg_write_d;
      op_rd_q        <= op_rd_d;
      op_addr_q      <= op_addr_d;
      op_data_q      <= op_data_d;
      stall_q        <= stall_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // Misaligned memory ops finish immediately without touching memory.
  assign mis_c      = !sel_lat_c && cur_is_mem_c && (cur_addr_c[2:0] != 3'd0);
  assign misalign_d = complete_c && mis_c;

  always_ff @(posedge clk or negedge rst_n) begin : misalign_reg
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign bus.misalign = misalign_q;
`else
  assign mis_c        = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  assign bus.stall        = stall_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_reg_write = wb_reg_write_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a transaction-level reference model.
module tb_memory_stage;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_stage_if bus();

  memory_stage #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        rd_;
    logic        wr;
    logic        to_reg;
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] addr;
    logic [63:0] data;
  } op_t;

  logic [63:0] mm [int];
  op_t         pend_op;
  bit          pend     = 0;
  longint      edge_n   = 0;
  longint      pend_due = 0;
  logic        e_stall = 0, e_valid = 0, e_rw = 0, e_mis = 0;
  logic [63:0] e_data = '0;
  logic [4:0]  e_rd   = '0;

  task automatic finish_op(input op_t o);
    int idx;
    idx     = int'((o.addr / 64'd8) % 64'(DEPTH));
    e_valid = 1'b1;
    e_rd    = o.rd;
    e_rw    = o.rw && (o.rd != 5'd0);
    e_data  = o.addr;
    if (o.wr) mm[idx] = o.data;
    else if (o.rd_ && o.to_reg) e_data = mm.exists(idx) ? mm[idx] : 64'hx;
  endtask

  initial begin
    op_t cur;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend = 0; e_stall = 0; e_valid = 0; e_rw = 0; e_mis = 0; e_data = '0; e_rd = '0;
      end else begin
        edge_n++;
        e_valid = 1'b0;
        e_mis   = 1'b0;
        if (pend) begin
          if (edge_n == pend_due) begin
            finish_op(pend_op);
            pend = 0;
          end
        end else if (bus.in_valid) begin
          cur.rd_ = bus.mem_read;  cur.wr = bus.mem_write; cur.to_reg = bus.mem_to_reg;
          cur.rw  = bus.reg_write; cur.rd = bus.rd_in;
          cur.addr = bus.alu_result; cur.data = bus.store_data;
`ifdef MEM_MISALIGN_TRAP_EN
          if ((cur.rd_ || cur.wr) && (cur.addr % 64'd8 != 0)) begin
            e_valid = 1'b1; e_mis = 1'b1; e_rw = 1'b0; e_data = cur.addr; e_rd = cur.rd;
          end else
`endif
          if ((cur.rd_ || cur.wr) && LATENCY > 0) begin
            pend = 1; pend_due = edge_n + longint'(LATENCY); pend_op = cur;
          end else begin
            finish_op(cur);
          end
        end
        e_stall = pend;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("stall",        64'(bus.stall),        64'(e_stall));
      check("wb_valid",     64'(bus.wb_valid),     64'(e_valid));
      check("wb_data",      bus.wb_data,           e_data);
      check("wb_rd",        64'(bus.wb_rd),        64'(e_rd));
      check("wb_reg_write", 64'(bus.wb_reg_write), 64'(e_rw));
      check("misalign",     64'(bus.misalign),     64'(e_mis));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_op(input logic r, input logic w, input logic tr, input logic rw,
                        input logic [4:0] rd, input logic [63:0] a, input logic [63:0] d);
    bus.in_valid = 1'b1; bus.mem_read = r; bus.mem_write = w; bus.mem_to_reg = tr;
    bus.reg_write = rw; bus.rd_in = rd; bus.alu_result = a; bus.store_data = d;
  endtask

  task automatic issue(input logic r, input logic w, input logic tr, input logic rw,
                       input logic [4:0] rd, input logic [63:0] a, input logic [63:0] d,
                       output int n);
    @(negedge clk);
    set_op(r, w, tr, rw, rd, a, d);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.stall === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("stall_bounded", 64'(n < 40), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 64'(bus.stall), 64'd0);
    check({tag, "_valid"}, 64'(bus.wb_valid), 64'd0);
    check({tag, "_data"},  bus.wb_data, 64'd0);
    check({tag, "_rd"},    64'(bus.wb_rd), 64'd0);
    check({tag, "_rw"},    64'(bus.wb_reg_write), 64'd0);
    check({tag, "_mis"},   64'(bus.misalign), 64'd0);
  endtask

  initial begin
    int n;
    bus.in_valid = 0; bus.mem_read = 0; bus.mem_write = 0; bus.mem_to_reg = 0;
    bus.reg_write = 0; bus.rd_in = '0; bus.alu_result = '0; bus.store_data = '0;

    repeat (3) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;

    // Back-to-back pass-through ops
    @(negedge clk);
    set_op(0, 0, 0, 1, 5'd5, 64'h1234, 64'h0);
    @(negedge clk);
    check("pt1_valid", 64'(bus.wb_valid), 64'd1);
    check("pt1_data",  bus.wb_data, 64'h1234);
    check("pt1_rd",    64'(bus.wb_rd), 64'd5);
    check("pt1_rw",    64'(bus.wb_reg_write), 64'd1);
    set_op(0, 0, 0, 1, 5'd0, 64'h99, 64'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pt2_valid", 64'(bus.wb_valid), 64'd1);
    check("pt2_data",  bus.wb_data, 64'h99);
    check("pt2_rw",    64'(bus.wb_reg_write), 64'd0);
    check("pt2_stall", 64'(bus.stall), 64'd0);

    // Store then load same doubleword
    issue(0, 1, 0, 0, 5'd0, 64'h40, 64'hDEADBEEF_CAFEF00D, n);
    check("st40_stall_cycles", 64'(n), 64'd2);
    check("st40_valid", 64'(bus.wb_valid), 64'd1);
    issue(1, 0, 1, 1, 5'd7, 64'h40, 64'h0, n);
    check("ld40_stall_cycles", 64'(n), 64'd2);
    check("ld40_data", bus.wb_data, 64'hDEADBEEF_CAFEF00D);
    check("ld40_rd",   64'(bus.wb_rd), 64'd7);
    check("ld40_rw",   64'(bus.wb_reg_write), 64'd1);

    // Load with mem_to_reg=0 returns the address; rd_in=0 kills the write enable
    issue(1, 0, 0, 1, 5'd6, 64'h40, 64'h0, n);
    check("ld_noreg_data", bus.wb_data, 64'h40);
    issue(1, 0, 1, 1, 5'd0, 64'h40, 64'h0, n);
    check("ld_rd0_rw", 64'(bus.wb_reg_write), 64'd0);

    // Address wrap at DEPTH*8
    issue(0, 1, 0, 0, 5'd0, 64'h800, 64'h5A5A, n);
    issue(1, 0, 1, 1, 5'd3, 64'h0, 64'h0, n);
    check("wrap_data", bus.wb_data, 64'h5A5A);

    // Read+write together behaves as a store
    issue(1, 1, 1, 1, 5'd1, 64'h10, 64'h33, n);
    check("rw_both_data", bus.wb_data, 64'h10);
    issue(1, 0, 1, 1, 5'd1, 64'h10, 64'h0, n);
    check("rw_both_load", bus.wb_data, 64'h33);

    // Reset while a store is in flight discards it
    issue(0, 1, 0, 0, 5'd0, 64'h48, 64'h1, n);
    @(negedge clk);
    set_op(0, 1, 0, 0, 5'd0, 64'h48, 64'h2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_mid_stall_before", 64'(bus.stall), 64'd1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst_mid");
    rst_n = 1'b1;
    issue(0, 0, 0, 1, 5'd2, 64'h77, 64'h0, n);
    check("post_rst_pt_stall", 64'(n), 64'd0);
    check("post_rst_pt_data",  bus.wb_data, 64'h77);
    check("post_rst_pt_rd",    64'(bus.wb_rd), 64'd2);
    issue(1, 0, 1, 1, 5'd4, 64'h48, 64'h0, n);
    check("post_rst_load", bus.wb_data, 64'h1);

    // Misaligned load at 0x44
    issue(1, 0, 1, 1, 5'd9, 64'h44, 64'h0, n);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_stall_cycles", 64'(n), 64'd0);
    check("mis_valid", 64'(bus.wb_valid), 64'd1);
    check("mis_flag",  64'(bus.misalign), 64'd1);
    check("mis_rw",    64'(bus.wb_reg_write), 64'd0);
    check("mis_data",  bus.wb_data, 64'h44);
`else
    check("mis_stall_cycles", 64'(n), 64'd2);
    check("mis_valid", 64'(bus.wb_valid), 64'd1);
    check("mis_flag",  64'(bus.misalign), 64'd0);
    check("mis_data",  bus.wb_data, 64'hDEADBEEF_CAFEF00D);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage of the RISC-V pipeline, directly downstream of execute. It consumes the ALU result as a doubleword address or pass-through value, together with the store data and control bits. It performs loads and stores against an internal doubleword data memory with a fixed, parameterised access latency, and delivers the write-back value, destination register and write enable to the write-back stage. While an access is in flight it stalls the upstream stage.

## Interface
- DEPTH, 256: data memory size in 64-bit doublewords; power of two; ADDR_W = $clog2(DEPTH).
- LATENCY, 2: wait cycles per memory access; legal range 0..15.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream instruction present.
- mem_read  input  1  load.
- mem_write  input  1  store.
- mem_to_reg  input  1  write-back selects load data rather than alu_result.
- reg_write  input  1  instruction writes rd.
- alu_result  input  64  address for memory ops; result for others.
- store_data  input  64  rd2 value to store.
- rd_in  input  5  destination register.
- stall  output  1  upstream must hold its outputs; registered.
- wb_valid  output  1  one-cycle completion pulse.
- wb_data  output  64  write-back value.
- wb_rd  output  5  write-back register.
- wb_reg_write  output  1  write-back enable.
- misalign  output  1  misaligned-access pulse; constant 0 when the trap is compiled out.

## Operation
- FSM states are IDLE and WAIT; cnt is a 4-bit down-counter.
- Accept: rising edge with in_valid=1 and state IDLE. In WAIT, in_valid is ignored and upstream holds its outputs.
- Non-memory op (mem_read=0, mem_write=0): completes at the accept edge.
  - wb_data=alu_result, wb_rd=rd_in, wb_reg_write=reg_write.
- Memory op with LATENCY=0: completes at the accept edge, like a non-memory op.
- Memory op with LATENCY>0: at the accept edge the block latches the op and moves to WAIT with cnt=LATENCY.
  - cnt decrements each edge.
  - The edge where cnt==1 is the completion edge; the FSM returns to IDLE.
- Index: alu_result[ADDR_W+2:3]. Upper bits are ignored, so addresses wrap modulo DEPTH*8.
- Store: mem[index] is written with store_data at the completion edge. wb_data=alu_result.
- Load: mem[index] is read at the completion edge. wb_data=mem[index] if mem_to_reg, else alu_result.
- mem_read=1 and mem_write=1 together: treated as a store.
- rd_in==0: wb_reg_write is forced to 0.
- Memory contents are not reset.
- Reset (any time, including in WAIT):
  - state goes to IDLE, cnt=0.
  - Any pending store is discarded and memory is not written.
  - All outputs go to 0.

## Timing
- Every completion edge sets wb_valid=1 for exactly one cycle. wb_data, wb_rd and wb_reg_write are updated at that edge and hold until the next completion.
- Non-memory op: accept at edge T gives wb_valid high in cycle T+1. stall stays 0, so back-to-back ops are sustained at one per cycle.
- Memory op: accept at edge T.
  - stall=1 from after edge T until edge T+LATENCY.
  - wb_valid is high for the cycle after edge T+LATENCY.
  - The next instruction is accepted at edge T+LATENCY.
- Store followed by load to the same index: the load observes the new data.
- Reset values: stall=0, wb_valid=0, wb_data=0, wb_rd=0, wb_reg_write=0, misalign=0.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: a memory op with alu_result[2:0]!=0 is handled as follows.
  - It completes at the accept edge with no WAIT.
  - wb_valid=1, misalign=1 for one cycle, wb_reg_write=0, wb_data=alu_result.
  - Memory is not written.
- Undefined: alu_result[2:0] is ignored and misalign is tied to 0.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-traffic -> all outputs 0. Release, then a pass-through op completes normally.
- Pass-through: alu_result=0x1234, rd_in=5, reg_write=1; next cycle alu_result=0x99, rd_in=0 -> two consecutive wb_valid pulses.
  - First: wb_data=0x1234, wb_rd=5, wb_reg_write=1.
  - Second: wb_reg_write=0.
  - stall never asserts.
- Store/load, LATENCY=2: store 0xDEADBEEF_CAFEF00D to 0x40, then load rd_in=7, mem_to_reg=1 from 0x40.
  - Each op: stall high 2 cycles, wb_valid 3 cycles after accept.
  - Load: wb_data=0xDEADBEEFCAFEF00D, wb_rd=7.
- Wrap, DEPTH=256: store 0x5A5A to 0x800, then load 0x0 -> wb_data=0x5A5A.
- Reset during access: store 0x1 to 0x48; start a store of 0x2 to 0x48, pull rst_n low during WAIT; after release, load 0x48 -> wb_data=0x1.
- Misaligned load at 0x44:
  - With MEM_MISALIGN_TRAP_EN: wb_valid and misalign high in the next cycle, wb_reg_write=0, stall never asserts.
  - Without it: load returns mem[8] after LATENCY+1 cycles and misalign=0.
